// File: rtl/mis_stimulus_gen_if.sv
// Command/status bundle between the MIS measurement controller (master)
// and the skewed stimulus generator (slave).
interface mis_stimulus_gen_if #(
   parameter int SKEW_W = 8,
   parameter int HOLD_W = 8,
   parameter int REP_W  = 8
);
   logic              start;
   logic              dir;
   logic [SKEW_W-1:0] skew;
   logic [HOLD_W-1:0] hold;
   logic [REP_W-1:0]  reps;
   logic              myinA1;
   logic              myinA2;
   logic              trig;
   logic              busy;
   logic              done;

   modport master (
      output start, dir, skew, hold, reps,
      input  myinA1, myinA2, trig, busy, done
   );

   modport slave (
      input  start, dir, skew, hold, reps,
      output myinA1, myinA2, trig, busy, done
   );
endinterface

// File: rtl/mis_stimulus_gen.sv
// Drives the two NOR-chain inputs with a programmable signed cycle skew,
// repeating settle/lead/hold sequences and flagging the first edge with trig.
module mis_stimulus_gen #(
   parameter int SKEW_W = 8,
   parameter int HOLD_W = 8,
   parameter int REP_W  = 8
) (
   input logic              clk,
   input logic              rst,
   mis_stimulus_gen_if.slave bus
);
   localparam int CNT_W = (SKEW_W > HOLD_W) ? SKEW_W : HOLD_W;

   typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_LEAD, S_HOLD, S_DONE} state_t;

   state_t            r_state, w_state;
   logic [CNT_W-1:0]  r_cnt, w_cnt;
   logic [SKEW_W-1:0] r_k, w_k;
   logic [HOLD_W-1:0] r_hold, w_hold;
   logic [REP_W-1:0]  r_reps, w_reps;
   logic              r_init, w_init;
   logic              r_lead_a2, w_lead_a2;
   logic              r_a1, w_a1;
   logic              r_a2, w_a2;
   logic              r_trig, w_trig;
   logic              r_busy, w_busy;
   logic              r_done, w_done;
   logic [SKEW_W-1:0] w_abs;

   // Magnitude kept unsigned so the most negative skew maps to 2^(SKEW_W-1).
   assign w_abs = bus.skew[SKEW_W-1] ? (~bus.skew + SKEW_W'(1)) : bus.skew;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_k       <= '0;
         r_hold    <= '0;
         r_reps    <= '0;
         r_init    <= 1'b0;
         r_lead_a2 <= 1'b0;
         r_a1      <= 1'b0;
         r_a2      <= 1'b0;
         r_trig    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_cnt     <= w_cnt;
         r_k       <= w_k;
         r_hold    <= w_hold;
         r_reps    <= w_reps;
         r_init    <= w_init;
         r_lead_a2 <= w_lead_a2;
         r_a1      <= w_a1;
         r_a2      <= w_a2;
         r_trig    <= w_trig;
         r_busy    <= w_busy;
         r_done    <= w_done;
      end
   end

   // Outputs are computed for the state being entered so every pin is a flop.
   always_comb begin
      w_state   = r_state;
      w_cnt     = r_cnt;
      w_k       = r_k;
      w_hold    = r_hold;
      w_reps    = r_reps;
      w_init    = r_init;
      w_lead_a2 = r_lead_a2;
      w_a1      = r_init;
      w_a2      = r_init;
      w_trig    = 1'b0;
      w_busy    = r_busy;
      w_done    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (bus.start) begin
               w_init    = bus.dir;
               w_k       = w_abs;
               w_hold    = bus.hold;
               w_reps    = bus.reps;
               w_lead_a2 = bus.skew[SKEW_W-1];
               w_cnt     = CNT_W'(bus.hold);
               w_a1      = bus.dir;
               w_a2      = bus.dir;
               if (bus.reps == '0) begin
                  w_state = S_DONE;
                  w_done  = 1'b1;
               end else begin
                  w_state = S_SETTLE;
                  w_busy  = 1'b1;
               end
            end
         end
         S_SETTLE: begin
            if (r_cnt == '0) begin
               w_trig = 1'b1;
               w_a1   = (!r_lead_a2 || r_k == '0) ? ~r_init : r_init;
               w_a2   = ( r_lead_a2 || r_k == '0) ? ~r_init : r_init;
               if (r_k == '0) begin
                  w_state = S_HOLD;
                  w_cnt   = CNT_W'(r_hold);
               end else begin
                  w_state = S_LEAD;
                  w_cnt   = CNT_W'(r_k) - CNT_W'(1);
               end
            end else begin
               w_cnt = r_cnt - CNT_W'(1);
            end
         end
         S_LEAD: begin
            w_a1 = r_lead_a2 ? r_init : ~r_init;
            w_a2 = r_lead_a2 ? ~r_init : r_init;
            if (r_cnt == '0) begin
               w_a1    = ~r_init;
               w_a2    = ~r_init;
               w_state = S_HOLD;
               w_cnt   = CNT_W'(r_hold);
            end else begin
               w_cnt = r_cnt - CNT_W'(1);
            end
         end
         S_HOLD: begin
            w_a1 = ~r_init;
            w_a2 = ~r_init;
            if (r_cnt == '0) begin
               w_a1   = r_init;
               w_a2   = r_init;
               w_reps = r_reps - REP_W'(1);
               if (r_reps == REP_W'(1)) begin
                  w_state = S_DONE;
                  w_busy  = 1'b0;
                  w_done  = 1'b1;
               end else begin
                  w_state = S_SETTLE;
                  w_cnt   = CNT_W'(r_hold);
               end
            end else begin
               w_cnt = r_cnt - CNT_W'(1);
            end
         end
         S_DONE: begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
         end
         default: begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
         end
      endcase
   end

   assign bus.myinA1 = r_a1;
   assign bus.myinA2 = r_a2;
   assign bus.trig   = r_trig;
   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
endmodule

// File: tb/tb_mis_stimulus_gen.sv
// Directed bench for mis_stimulus_gen: per-cycle output logs after the start
// edge are compared against hand-computed edge positions.
module tb_mis_stimulus_gen;
   localparam int LOGN = 160;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   seen;

   logic [LOGN-1:0] lg_a1, lg_a2, lg_trig, lg_busy, lg_done;

   mis_stimulus_gen_if #(.SKEW_W(8), .HOLD_W(8), .REP_W(8)) bus ();

   mis_stimulus_gen #(.SKEW_W(8), .HOLD_W(8), .REP_W(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, $signed(act), $signed(exp));
      end
   endtask

   function automatic int first_at(input logic [LOGN-1:0] v, input logic val, input int from);
      for (int i = from; i < LOGN; i++)
         if (v[i] === val) return i;
      return -1;
   endfunction

   task automatic rec(input int k);
      lg_a1[k]   = bus.myinA1;
      lg_a2[k]   = bus.myinA2;
      lg_trig[k] = bus.trig;
      lg_busy[k] = bus.busy;
      lg_done[k] = bus.done;
   endtask

   // Index k holds outputs sampled just after edge E0+k; inputs are scrambled
   // after acceptance, and an optional stray start is pulsed at index spulse.
   task automatic run(input logic d, input logic [7:0] sk, input logic [7:0] hd,
                      input logic [7:0] rp, input int ncyc, input int spulse);
      lg_a1 = '0; lg_a2 = '0; lg_trig = '0; lg_busy = '0; lg_done = '0;
      @(negedge clk);
      bus.dir = d; bus.skew = sk; bus.hold = hd; bus.reps = rp; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0; bus.dir = ~d; bus.skew = 8'h11; bus.hold = 8'h07; bus.reps = 8'h09;
      rec(0);
      for (int k = 1; k < ncyc; k++) begin
         @(posedge clk);
         #1;
         rec(k);
         bus.start = (k == spulse);
      end
      bus.start = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 1'b0; bus.dir = 1'b0; bus.skew = '0; bus.hold = '0; bus.reps = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_a1", bus.myinA1, 0);
      check("rst_a2", bus.myinA2, 0);
      check("rst_trig", bus.trig, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      @(negedge clk) rst = 1'b0;

      // skew 0, hold 3
      run(1'b0, 8'd0, 8'd3, 8'd1, 12, -1);
      check("t1_busy0", lg_busy[0], 1);
      check("t1_a1_rise", first_at(lg_a1, 1'b1, 0), 4);
      check("t1_a2_rise", first_at(lg_a2, 1'b1, 0), 4);
      check("t1_trig_at", first_at(lg_trig, 1'b1, 0), 4);
      check("t1_trig_cnt", $countones(lg_trig), 1);
      check("t1_a1_fall", first_at(lg_a1, 1'b0, 4), 8);
      check("t1_a2_fall", first_at(lg_a2, 1'b0, 4), 8);
      check("t1_done_at", first_at(lg_done, 1'b1, 0), 8);
      check("t1_busy8", lg_busy[8], 0);
      check("t1_busy7", lg_busy[7], 1);
      check("t1_done_cnt", $countones(lg_done), 1);

      // skew +5, hold 2, stray start while busy
      run(1'b0, 8'd5, 8'd2, 8'd1, 14, 5);
      check("t2_a1_rise", first_at(lg_a1, 1'b1, 0), 3);
      check("t2_trig_at", first_at(lg_trig, 1'b1, 0), 3);
      check("t2_a2_rise", first_at(lg_a2, 1'b1, 0), 8);
      check("t2_a1_fall", first_at(lg_a1, 1'b0, 3), 11);
      check("t2_a2_fall", first_at(lg_a2, 1'b0, 8), 11);
      check("t2_done_at", first_at(lg_done, 1'b1, 0), 11);
      check("t2_done_cnt", $countones(lg_done), 1);

      // dir 1, skew -3, hold 1, two reps
      run(1'b1, 8'hFD, 8'd1, 8'd2, 18, -1);
      check("t3_a1_init", lg_a1[0], 1);
      check("t3_a2_init", lg_a2[0], 1);
      check("t3_a2_fall1", first_at(lg_a2, 1'b0, 0), 2);
      check("t3_a1_fall1", first_at(lg_a1, 1'b0, 0), 5);
      check("t3_a2_ret1", first_at(lg_a2, 1'b1, 2), 7);
      check("t3_a1_ret1", first_at(lg_a1, 1'b1, 5), 7);
      check("t3_a2_fall2", first_at(lg_a2, 1'b0, 7), 9);
      check("t3_a1_fall2", first_at(lg_a1, 1'b0, 7), 12);
      check("t3_a1_ret2", first_at(lg_a1, 1'b1, 12), 14);
      check("t3_done_at", first_at(lg_done, 1'b1, 0), 14);
      check("t3_trig_cnt", $countones(lg_trig), 2);
      check("t3_trig2_at", first_at(lg_trig, 1'b1, 3), 9);
      check("t3_busy13", lg_busy[13], 1);
      check("t3_busy14", lg_busy[14], 0);

      // most negative skew
      run(1'b0, 8'h80, 8'd0, 8'd1, 140, -1);
      check("t4_a2_rise", first_at(lg_a2, 1'b1, 0), 1);
      check("t4_a1_rise", first_at(lg_a1, 1'b1, 0), 129);
      check("t4_a1_fall", first_at(lg_a1, 1'b0, 129), 130);
      check("t4_done_at", first_at(lg_done, 1'b1, 0), 130);

      // zero repetitions
      run(1'b0, 8'd3, 8'd2, 8'd0, 4, -1);
      check("t5_done_at", first_at(lg_done, 1'b1, 0), 0);
      check("t5_done_cnt", $countones(lg_done), 1);
      check("t5_busy_cnt", $countones(lg_busy), 0);
      check("t5_edges", $countones(lg_a1 | lg_a2 | lg_trig), 0);

      // reset during LEAD with dir 1
      @(negedge clk);
      bus.dir = 1'b1; bus.skew = 8'd4; bus.hold = 8'd2; bus.reps = 8'd1; bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("t6_pre_a1", bus.myinA1, 0);
      check("t6_pre_a2", bus.myinA2, 1);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_a1", bus.myinA1, 0);
      check("t6_rst_a2", bus.myinA2, 0);
      check("t6_rst_busy", bus.busy, 0);
      @(negedge clk) rst = 1'b0;
      seen = 0;
      repeat (12) begin
         @(posedge clk);
         #1 seen += int'(bus.done);
      end
      check("t6_no_done", seen, 0);

      run(1'b0, 8'd0, 8'd3, 8'd1, 12, -1);
      check("t7_a1_rise", first_at(lg_a1, 1'b1, 0), 4);
      check("t7_done_at", first_at(lg_done, 1'b1, 0), 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
